// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: fetches one instruction word per valid/ready handshake and
// sequences it through FETCH/DECODE/EXEC/MEM_WAIT/WB, driving datapath, memory and PC control.
module multicycle_control_unit #(
    parameter  int OP_W    = 4,
    parameter  int REG_AW  = 3,
    parameter  int PC_W    = 8,
    parameter  int CNT_W   = 16,
    localparam int INSTR_W = OP_W + 2 * REG_AW,
    localparam int MEM_AW  = 2 * REG_AW
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic               mem_ready,
    input  logic               zero_flag,
    output logic [REG_AW-1:0]  addr_a,
    output logic [REG_AW-1:0]  addr_b,
    output logic               reg_reset,
    output logic               reg_reset_all,
    output logic               reg_load,
    output logic               mb_select,
    output logic [3:0]         alu_opcode,
    output logic               mem_read,
    output logic               mem_write,
    output logic [MEM_AW-1:0]  mem_addr,
    output logic               mem_select,
    output logic               load_pc,
    output logic               pc_inc,
    output logic [PC_W-1:0]    pc_value,
    output logic               out_valid,
    output logic               halted,
    output logic [CNT_W-1:0]   retired
);

    localparam logic [2:0] S_FETCH    = 3'd0;
    localparam logic [2:0] S_DECODE   = 3'd1;
    localparam logic [2:0] S_EXEC     = 3'd2;
    localparam logic [2:0] S_MEM_WAIT = 3'd3;
    localparam logic [2:0] S_WB       = 3'd4;
    localparam logic [2:0] S_HALT     = 3'd5;

    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUBI  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_MUL2  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_DIV2  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_CLR   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_RST   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_MOV   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_JMP   = OP_W'(9);
    localparam logic [OP_W-1:0] OP_OUT   = OP_W'(10);
    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(11);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(12);
    localparam logic [OP_W-1:0] OP_JZ    = OP_W'(13);
    localparam logic [OP_W-1:0] OP_JNZ   = OP_W'(14);
    localparam logic [OP_W-1:0] OP_HLT   = OP_W'(15);

    logic [2:0]         state;
    logic [2:0]         next_state;
    logic [INSTR_W-1:0] ir;
    logic               zf_q;
    logic               retire;

    logic [OP_W-1:0]   opcode;
    logic [REG_AW-1:0] reg_a_f;
    logic [REG_AW-1:0] reg_b_f;
    logic [MEM_AW-1:0] operand;

    assign opcode  = ir[INSTR_W-1 -: OP_W];
    assign reg_a_f = ir[2*REG_AW-1 -: REG_AW];
    assign reg_b_f = ir[REG_AW-1:0];
    assign operand = ir[MEM_AW-1:0];

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:    if (instr_valid) next_state = S_DECODE;
            S_DECODE:   next_state = S_EXEC;
            S_EXEC: begin
                if (opcode == OP_LOAD || opcode == OP_STORE) next_state = S_MEM_WAIT;
                else if (opcode == OP_HLT)                    next_state = S_HALT;
                else                                          next_state = S_FETCH;
            end
            S_MEM_WAIT: if (mem_ready) next_state = S_WB;
            S_WB:       next_state = S_FETCH;
            S_HALT:     next_state = S_HALT;
            default:    next_state = S_FETCH;
        endcase
    end

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        instr_ready   = 1'b0;
        addr_a        = '0;
        addr_b        = '0;
        reg_reset     = 1'b0;
        reg_reset_all = 1'b0;
        reg_load      = 1'b0;
        mb_select     = 1'b0;
        alu_opcode    = 4'b0000;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_addr      = '0;
        mem_select    = 1'b0;
        load_pc       = 1'b0;
        pc_inc        = 1'b0;
        pc_value      = '0;
        out_valid     = 1'b0;
        halted        = 1'b0;
        case (state)
            S_FETCH:  instr_ready = 1'b1;
            S_DECODE: begin
                addr_a = reg_a_f;
                addr_b = reg_b_f;
            end
            S_EXEC: begin
                addr_a = reg_a_f;
                addr_b = reg_b_f;
                case (opcode)
                    OP_ADD, OP_SUB: begin
                        alu_opcode = (opcode == OP_SUB) ? 4'b0001 : 4'b0000;
                        mb_select  = 1'b1;
                        reg_load   = 1'b1;
                        pc_inc     = 1'b1;
                    end
                    OP_ADDI, OP_SUBI: begin
                        alu_opcode = (opcode == OP_SUBI) ? 4'b0001 : 4'b0000;
                        reg_load   = 1'b1;
                        pc_inc     = 1'b1;
                    end
                    OP_MUL2, OP_DIV2: begin
                        alu_opcode = (opcode == OP_DIV2) ? 4'b0011 : 4'b0010;
                        addr_b     = '0;
                        reg_load   = 1'b1;
                        pc_inc     = 1'b1;
                    end
                    OP_CLR: begin
                        reg_reset = 1'b1;
                        pc_inc    = 1'b1;
                    end
                    OP_RST: begin
                        reg_reset_all = 1'b1;
                        pc_inc        = 1'b1;
                    end
                    OP_MOV: begin
                        alu_opcode = 4'b0100;
                        mb_select  = 1'b1;
                        reg_load   = 1'b1;
                        pc_inc     = 1'b1;
                    end
                    OP_OUT: begin
                        out_valid = 1'b1;
                        pc_inc    = 1'b1;
                    end
                    OP_JMP: begin
                        load_pc  = 1'b1;
                        pc_value = PC_W'(operand);
                    end
                    // Branch condition uses the zero flag captured on entry to EXEC.
                    OP_JZ, OP_JNZ: begin
                        if (zf_q == (opcode == OP_JZ)) begin
                            load_pc  = 1'b1;
                            pc_value = PC_W'(operand);
                        end else begin
                            pc_inc = 1'b1;
                        end
                    end
                    OP_LOAD, OP_STORE: begin
                        addr_a    = '0;
                        mem_addr  = operand;
                        mem_read  = (opcode == OP_LOAD);
                        mem_write = (opcode == OP_STORE);
                    end
                    default: ;
                endcase
            end
            S_MEM_WAIT: begin
                mem_addr  = operand;
                mem_read  = (opcode == OP_LOAD);
                mem_write = (opcode == OP_STORE);
            end
            S_WB: begin
                pc_inc = 1'b1;
                if (opcode == OP_LOAD) begin
                    mem_select = 1'b1;
                    reg_load   = 1'b1;
                end
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign retire = pc_inc | load_pc | (state == S_EXEC && opcode == OP_HLT);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_FETCH;
            ir      <= '0;
            zf_q    <= 1'b0;
            retired <= '0;
        end else begin
            state <= next_state;
            if (state == S_FETCH && instr_valid) ir <= instr;
            if (state == S_DECODE) zf_q <= zero_flag;
            if (retire && retired != '1) retired <= retired + CNT_W'(1);
        end
    end

endmodule
